// File: rtl/bin_threshold_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bin_threshold_ctrl
// Description : Frame-synchronous threshold controller for Y-to-binary
//               thresholding. Auto mode divides the frame luma sum by the
//               pixel count, adds a signed offset and clamps to 0..255.
//               Manual mode forwards a configured value. The threshold is
//               only reloaded at the start of active video.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_threshold_ctrl #(
  parameter int         SUM_W    = 32,
  parameter logic [7:0] INIT_THR = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_de,
  input  logic [7:0] img_y,
  input  logic       cfg_auto_en,
  input  logic [7:0] cfg_manual_thr,
  input  logic [7:0] cfg_offset,
  input  logic       cfg_clr_flags,
  output logic [7:0] threshold,
  output logic [7:0] mean_y,
  output logic       thr_update,
  output logic       calc_busy,
  output logic       overrun_flag,
  output logic       zero_frame_flag
);

  localparam int CNT_W = SUM_W - 8;
  localparam int REM_W = CNT_W + 1;
  localparam int IT_W  = $clog2(SUM_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              r_vsync_d;
  logic              w_rise;
  logic              w_fall;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_state;
  logic [IT_W-1:0]   r_iter;
  logic [SUM_W-1:0]  r_quo;
  logic [REM_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_div;
  logic [7:0]        r_pend_thr;
  logic              r_pend_vld;
  logic [SUM_W:0]    w_sum_inc;
  logic [REM_W-1:0]  w_rem_sh;
  logic [REM_W:0]    w_diff;
  logic              w_ge;
  logic signed [9:0] w_sum10;
  logic [7:0]        w_clamp;
  logic              w_ovr_set;
  logic              w_zero_set;

  assign w_rise    = pre_frame_vsync & ~r_vsync_d;
  assign w_fall    = ~pre_frame_vsync & r_vsync_d;
  assign calc_busy = (r_state == S_DIV);

  // Saturating sum: a carry out of the accumulator pins it at all-ones.
  assign w_sum_inc = {1'b0, r_sum} + {{(SUM_W-7){1'b0}}, img_y};

  // Restoring divider step; remainder stays below the divisor, so one extra bit suffices.
  assign w_rem_sh = {r_rem[REM_W-2:0], r_quo[SUM_W-1]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_div};
  assign w_ge     = ~w_diff[REM_W];

  // Offset is applied in 10-bit signed so both clamp directions are visible.
  assign w_sum10 = $signed({2'b00, r_quo[7:0]}) + $signed({{2{cfg_offset[7]}}, cfg_offset});
  assign w_clamp = w_sum10[9] ? 8'd0 : (w_sum10[8] ? 8'd255 : w_sum10[7:0]);

  assign w_ovr_set  = (w_rise & (r_state == S_DIV)) |
                      (w_fall & cfg_auto_en & ~r_pend_vld & calc_busy);
  assign w_zero_set = w_rise & (r_cnt == '0);

  // Vsync delay register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vsync_d <= 1'b0;
    else        r_vsync_d <= pre_frame_vsync;
  end

  // Per-frame luma sum and pixel count; restarted on vsync rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_rise) begin
      r_sum <= pre_frame_de ? {{(SUM_W-8){1'b0}}, img_y} : '0;
      r_cnt <= pre_frame_de ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (pre_frame_de) begin
      r_sum <= w_sum_inc[SUM_W] ? '1 : w_sum_inc[SUM_W-1:0];
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Divider FSM: snapshot on rise, one quotient bit per cycle, a rise mid-divide restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
    end else if (w_rise) begin
      r_quo   <= r_sum;
      r_div   <= r_cnt;
      r_rem   <= '0;
      r_iter  <= '0;
      r_state <= (r_cnt != '0) ? S_DIV : S_IDLE;
    end else begin
      case (r_state)
        S_DIV: begin
          r_rem  <= w_ge ? w_diff[REM_W-1:0] : w_rem_sh;
          r_quo  <= {r_quo[SUM_W-2:0], w_ge};
          r_iter <= r_iter + 1'b1;
          if (r_iter == IT_W'(SUM_W - 1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture the finished mean and the clamped candidate threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_y     <= 8'd0;
      r_pend_thr <= 8'd0;
      r_pend_vld <= 1'b0;
    end else if (r_state == S_DONE) begin
      mean_y     <= r_quo[7:0];
      r_pend_thr <= w_clamp;
      r_pend_vld <= 1'b1;
    end else if (w_fall && cfg_auto_en && r_pend_vld) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Threshold reload at start of active video only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold  <= INIT_THR;
      thr_update <= 1'b0;
    end else begin
      thr_update <= 1'b0;
      if (w_fall) begin
        if (!cfg_auto_en) begin
          threshold  <= cfg_manual_thr;
          thr_update <= 1'b1;
        end else if (r_pend_vld) begin
          threshold  <= r_pend_thr;
          thr_update <= 1'b1;
        end
      end
    end
  end

  // Sticky status flags; a set event in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_flag    <= 1'b0;
      zero_frame_flag <= 1'b0;
    end else begin
      if (w_ovr_set)          overrun_flag <= 1'b1;
      else if (cfg_clr_flags) overrun_flag <= 1'b0;
      if (w_zero_set)         zero_frame_flag <= 1'b1;
      else if (cfg_clr_flags) zero_frame_flag <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_threshold_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_threshold_ctrl
// Description : Scoreboard bench for bin_threshold_ctrl. Expected threshold
//               and mean values are queued per frame; a monitor pops one
//               entry for every thr_update pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_threshold_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pre_frame_vsync;
  logic       pre_frame_de;
  logic [7:0] img_y;
  logic       cfg_auto_en;
  logic [7:0] cfg_manual_thr;
  logic [7:0] cfg_offset;
  logic       cfg_clr_flags;
  logic [7:0] threshold;
  logic [7:0] mean_y;
  logic       thr_update;
  logic       calc_busy;
  logic       overrun_flag;
  logic       zero_frame_flag;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];
  logic        prev_upd = 1'b0;

  bin_threshold_ctrl #(.SUM_W(32), .INIT_THR(8'd128)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pre_frame_vsync (pre_frame_vsync),
    .pre_frame_de    (pre_frame_de),
    .img_y           (img_y),
    .cfg_auto_en     (cfg_auto_en),
    .cfg_manual_thr  (cfg_manual_thr),
    .cfg_offset      (cfg_offset),
    .cfg_clr_flags   (cfg_clr_flags),
    .threshold       (threshold),
    .mean_y          (mean_y),
    .thr_update      (thr_update),
    .calc_busy       (calc_busy),
    .overrun_flag    (overrun_flag),
    .zero_frame_flag (zero_frame_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // 4x2 active region with blanking; use_de=0 gives a frame with no pixels.
  task automatic active(input logic [7:0] y, input bit use_de);
    repeat (20) tick();
    for (int ln = 0; ln < 2; ln++) begin
      for (int px = 0; px < 4; px++) begin
        pre_frame_de = use_de;
        img_y        = y;
        tick();
      end
      pre_frame_de = 1'b0;
      repeat (8) tick();
    end
  endtask

  // Vsync pulse; returns two cycles after the falling-edge reload.
  task automatic vpulse(input int high_cycles);
    pre_frame_vsync = 1'b1;
    repeat (high_cycles) tick();
    pre_frame_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic push(input logic [7:0] thr, input logic [7:0] mean);
    exp_q.push_back({thr, mean});
  endtask

  // Monitor: every thr_update pulse is checked against the scoreboard.
  always @(negedge clk) begin
    logic [15:0] e;
    if (prev_upd) chk("thr_update_width", {31'd0, thr_update}, 32'd0);
    if (thr_update) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_update: got threshold %0d expected no update", threshold);
      end else begin
        e = exp_q.pop_front();
        chk("upd_threshold", {24'd0, threshold}, {24'd0, e[15:8]});
        chk("upd_mean_y",    {24'd0, mean_y},    {24'd0, e[7:0]});
      end
    end
    prev_upd = thr_update;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    pre_frame_vsync = 1'b0;
    pre_frame_de    = 1'b0;
    img_y           = 8'd0;
    cfg_auto_en     = 1'b1;
    cfg_manual_thr  = 8'd0;
    cfg_offset      = 8'd0;
    cfg_clr_flags   = 1'b0;
    repeat (3) tick();
    chk("rst_threshold",  {24'd0, threshold}, 32'd128);
    chk("rst_mean_y",     {24'd0, mean_y},    32'd0);
    chk("rst_thr_update", {31'd0, thr_update}, 32'd0);
    chk("rst_calc_busy",  {31'd0, calc_busy},  32'd0);
    chk("rst_overrun",    {31'd0, overrun_flag}, 32'd0);
    chk("rst_zero_frame", {31'd0, zero_frame_flag}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero frame: no pixels, threshold stays at reset value, no update.
    active(8'd0, 1'b0);
    vpulse(40);
    chk("zero_flag_set",  {31'd0, zero_frame_flag}, 32'd1);
    chk("zero_threshold", {24'd0, threshold}, 32'd128);
    cfg_clr_flags = 1'b1;
    tick();
    cfg_clr_flags = 1'b0;
    tick();
    chk("zero_flag_clr", {31'd0, zero_frame_flag}, 32'd0);

    // Auto mode, offset 0, then clamp high and low.
    active(8'd100, 1'b1);
    push(8'd100, 8'd100);
    vpulse(40);
    cfg_offset = 8'h78;
    active(8'd100, 1'b1);
    push(8'd220, 8'd100);
    vpulse(40);
    active(8'd200, 1'b1);
    push(8'd255, 8'd200);
    vpulse(40);
    cfg_offset = 8'h80;
    active(8'd50, 1'b1);
    push(8'd0, 8'd50);
    vpulse(40);
    chk("clamp_low_thr", {24'd0, threshold}, 32'd0);

    // Short vsync: divider still busy at the fall.
    cfg_offset = 8'h00;
    active(8'd80, 1'b1);
    vpulse(5);
    chk("short_overrun",   {31'd0, overrun_flag}, 32'd1);
    chk("short_threshold", {24'd0, threshold}, 32'd0);
    active(8'd60, 1'b1);
    push(8'd80, 8'd80);
    vpulse(5);
    active(8'd60, 1'b1);
    push(8'd60, 8'd60);
    vpulse(40);
    cfg_clr_flags = 1'b1;
    tick();
    cfg_clr_flags = 1'b0;
    tick();
    chk("overrun_clr", {31'd0, overrun_flag}, 32'd0);

    // Manual mode with a mid-frame configuration change.
    cfg_auto_en    = 1'b0;
    cfg_manual_thr = 8'd30;
    active(8'd70, 1'b1);
    push(8'd30, 8'd70);
    vpulse(40);
    active(8'd70, 1'b1);
    cfg_manual_thr = 8'd90;
    tick();
    chk("manual_midframe", {24'd0, threshold}, 32'd30);
    push(8'd90, 8'd70);
    vpulse(40);

    // Reset while dividing.
    cfg_auto_en = 1'b1;
    active(8'd100, 1'b1);
    pre_frame_vsync = 1'b1;
    repeat (10) tick();
    chk("busy_before_rst", {31'd0, calc_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("busy_after_rst", {31'd0, calc_busy}, 32'd0);
    chk("thr_after_rst",  {24'd0, threshold}, 32'd128);
    chk("mean_after_rst", {24'd0, mean_y},    32'd0);
    pre_frame_vsync = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_threshold_ctrl.md
Name: bin_threshold_ctrl

Overview:
- Frame-synchronous threshold controller for the Y-to-binary thresholding stage.
- In auto mode it accumulates the mean luma of each frame with an iterative divider, applies a signed offset, and clamps the result to 0..255. In manual mode it forwards a configured value.
- The new threshold is applied only at the start of active video, so the value never changes mid-frame.
- Sits in parallel with the thresholding stage, tapping the same pre-frame sync/DE/Y stream; `threshold` drives that stage's threshold input.

Parameters:
- SUM_W, 32, width of the luma sum accumulator and of the divider; SUM_W-8 is also the pixel-count width.
- INIT_THR, 128, threshold value after reset.

Ports:
- clk  in  1  module clock
- rst_n  in  1  asynchronous active-low reset
- pre_frame_vsync  in  1  vsync, active high; rising edge = end of frame, falling edge = start of next frame
- pre_frame_de  in  1  pixel valid
- img_y  in  8  luma sample, qualified by pre_frame_de
- cfg_auto_en  in  1  1 = auto (mean-based) threshold, 0 = manual
- cfg_manual_thr  in  8  manual threshold
- cfg_offset  in  8  signed two's-complement offset added to the mean
- cfg_clr_flags  in  1  one-cycle pulse; clears the sticky flags
- threshold  out  8  threshold applied to the thresholding stage
- mean_y  out  8  last computed frame mean
- thr_update  out  1  one-cycle pulse when threshold is loaded
- calc_busy  out  1  divider running
- overrun_flag  out  1  sticky; result not ready at frame start, or calculation aborted
- zero_frame_flag  out  1  sticky; a frame had no DE pixels

Behaviour:
- Reset values: threshold=INIT_THR, mean_y=0, thr_update=0, calc_busy=0, both flags=0. All internal state is cleared: accumulators, FSM to IDLE, pending invalid, vsync delay register.
- Edge detection: vsync_d is a registered copy of vsync. rise = vsync & ~vsync_d; fall = ~vsync & vsync_d.
- Accumulation, each cycle with pre_frame_de=1:
  - sum += img_y (SUM_W bits);
  - cnt += 1 (SUM_W-8 bits);
  - both saturate at all-ones.
- On rise:
  - snapshot sum/cnt into the divider;
  - clear sum/cnt in the same cycle; a DE pixel in that cycle starts the new sum (sum=img_y, cnt=1).
- FSM states: IDLE, DIV, DONE.
  - IDLE->DIV on rise with cnt_snap!=0.
  - IDLE stays IDLE on rise with cnt_snap==0; sets zero_frame_flag; pending is unchanged.
  - DIV: restoring division sum_snap/cnt_snap, one quotient bit per cycle, exactly SUM_W cycles; calc_busy=1.
  - DIV->DONE after the last iteration. In DONE (one cycle):
    - mean_y = quotient[7:0] (quotient ≤255 by construction);
    - pending_thr = clamp(mean + sign-extended cfg_offset, 0, 255), computed in 10-bit signed;
    - pending_valid=1;
    - next state IDLE.
  - rise while in DIV: abort, set overrun_flag, restart DIV with the new snapshot (or go to IDLE if its count is 0).
- Apply on fall:
  - auto and pending_valid: threshold<=pending_thr, pending_valid<=0, thr_update=1.
  - auto and calc_busy: threshold unchanged, set overrun_flag; the result is applied at the following fall.
  - auto with no pending: threshold unchanged, no pulse.
  - manual: threshold<=cfg_manual_thr, thr_update=1. cfg changes mid-frame have no effect until the next fall.
- Latency: DIV is entered the cycle after rise; the result is valid SUM_W+1 cycles after rise.
- Simultaneous events:
  - cfg_clr_flags on the same cycle as a set event: set wins.
  - rise and fall cannot coincide (guaranteed by edge detection).
- Mode switch mid-frame: takes effect at the next fall. Auto computation runs in both modes, so mean_y stays current.
- Reset mid-division: divider discarded, returns to the reset state.

Test Plan:
- Auto, offset 0: 4x2 frame all Y=100, then vsync high for 40 cycles, then low. Expect mean_y=100 and threshold=100 at the fall, with thr_update high for exactly 1 cycle.
- Clamp high: Y=100, cfg_offset=+120 (8'h78). Expect threshold=220. Then Y=200 with the same offset: expect threshold=255.
- Clamp low: Y=50, cfg_offset=-128 (8'h80). Expect threshold=0.
- Zero frame: frame with DE never asserted. Expect zero_frame_flag=1, threshold unchanged (INIT_THR=128), and no thr_update. Then cfg_clr_flags pulse: expect the flag to clear.
- Short vsync: vsync high for 5 cycles (less than SUM_W). Expect overrun_flag=1 and threshold unchanged at that fall; the new value is applied at the next fall.
- Manual mode: cfg_auto_en=0, cfg_manual_thr changed from 30 to 90 mid-frame. Expect threshold to stay 30 until the fall, then become 90. Assert rst_n mid-DIV: expect calc_busy=0 and threshold=128 immediately.
